// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for mem_bus_arbiter: fetch port, MEM-stage data port, stall
// request and the single-port SRAM controls. The arbiter connects through
// the slave modport; the pipeline/SRAM side (or a bench) uses master.
interface mem_bus_arbiter_if;
   // Fetch port
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_rdata_o;
   logic        if_done_o;
   // MEM-stage data port
   logic        mem_req_i;
   logic        mem_we_i;
   logic [3:0]  mem_sel_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_wdata_i;
   logic [31:0] mem_rdata_o;
   logic        mem_done_o;
   // Pipeline stall request
   logic        stall_req_o;
   // SRAM side
   logic        sram_ce_o;
   logic        sram_we_o;
   logic [3:0]  sram_sel_o;
   logic [31:0] sram_addr_o;
   logic [31:0] sram_wdata_o;
   logic [31:0] sram_rdata_i;

   modport slave (
      input  if_req_i, if_addr_i,
      input  mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
      input  sram_rdata_i,
      output if_rdata_o, if_done_o,
      output mem_rdata_o, mem_done_o,
      output stall_req_o,
      output sram_ce_o, sram_we_o, sram_sel_o, sram_addr_o, sram_wdata_o
   );

   modport master (
      output if_req_i, if_addr_i,
      output mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
      output sram_rdata_i,
      input  if_rdata_o, if_done_o,
      input  mem_rdata_o, mem_done_o,
      input  stall_req_o,
      input  sram_ce_o, sram_we_o, sram_sel_o, sram_addr_o, sram_wdata_o
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and the
// MEM-stage data port. Each access runs IDLE -> BUSY (WAIT_CYCLES cycles of
// held SRAM controls) -> RESP (one-cycle done pulse). Data accesses win ties,
// except that fetch is granted after MAX_STREAK consecutive MEM wins while
// it was waiting.
//
// Handshake: a requester raises req with its fields stable and holds them
// until the matching one-cycle done pulse; it drops or renews req on the edge
// after done. Requests are only evaluated in IDLE.
//
// dbg_state_o encoding: 0 = IDLE, 1 = BUSY, 2 = RESP.
module mem_bus_arbiter #(
   parameter int WAIT_CYCLES = 2,
   parameter int MAX_STREAK  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   mem_bus_arbiter_if.slave       bus,
   output logic [1:0]             dbg_state_o
);

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam int STK_W = $clog2(MAX_STREAK + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
   localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_STREAK);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [STK_W-1:0]  streak_q, streak_d;
   logic              gnt_mem_q, gnt_mem_d;   // 1 = current access belongs to MEM
   logic              we_q, we_d;
   logic [3:0]        sel_q, sel_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic [31:0]       mem_rdata_q, mem_rdata_d;
   logic              grant_mem;
   logic              busy;
   logic              if_done;
   logic              mem_done;

   // Next-state: arbitration and field latching in IDLE, hold-window count in BUSY
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      streak_d    = streak_q;
      gnt_mem_d   = gnt_mem_q;
      we_d        = we_q;
      sel_d       = sel_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      grant_mem   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.if_req_i || bus.mem_req_i) begin
               // MEM wins unless fetch is waiting and has lost MAX_STREAK times
               grant_mem = bus.mem_req_i &
                           ~(bus.if_req_i & (streak_q == STK_MAX));
               gnt_mem_d = grant_mem;
               cnt_d     = '0;
               state_d   = S_BUSY;
               if (grant_mem) begin
                  we_d    = bus.mem_we_i;
                  sel_d   = bus.mem_sel_i;
                  addr_d  = bus.mem_addr_i;
                  wdata_d = bus.mem_wdata_i;
                  if (bus.if_req_i) begin
                     streak_d = (streak_q == STK_MAX) ? STK_MAX : streak_q + 1'b1;
                  end else begin
                     streak_d = '0;
                  end
               end else begin
                  we_d     = 1'b0;
                  sel_d    = 4'b1111;
                  addr_d   = bus.if_addr_i;
                  wdata_d  = '0;
                  streak_d = '0;
               end
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               // SRAM read data is valid in the last cycle of the hold window
               if (!we_q) begin
                  if (gnt_mem_q) mem_rdata_d = bus.sram_rdata_i;
                  else           if_rdata_d  = bus.sram_rdata_i;
               end
               cnt_d   = '0;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any access in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         streak_q    <= '0;
         gnt_mem_q   <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         streak_q    <= streak_d;
         gnt_mem_q   <= gnt_mem_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign busy     = (state_q == S_BUSY);
   assign if_done  = (state_q == S_RESP) & ~gnt_mem_q;
   assign mem_done = (state_q == S_RESP) &  gnt_mem_q;

   // SRAM controls are driven only inside the hold window, zero otherwise
   assign bus.sram_ce_o    = busy;
   assign bus.sram_we_o    = busy & we_q;
   assign bus.sram_sel_o   = busy ? sel_q   : 4'b0000;
   assign bus.sram_addr_o  = busy ? addr_q  : 32'h0;
   assign bus.sram_wdata_o = busy ? wdata_q : 32'h0;

   assign bus.if_done_o   = if_done;
   assign bus.mem_done_o  = mem_done;
   assign bus.if_rdata_o  = if_rdata_q;
   assign bus.mem_rdata_o = mem_rdata_q;

   // A port keeps the pipeline stalled until its own done pulse
   assign bus.stall_req_o = (bus.if_req_i  & ~if_done) |
                            (bus.mem_req_i & ~mem_done);

   assign dbg_state_o = state_q;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares one single-port synchronous SRAM between the instruction-fetch port and the MEM-stage data port of the five-stage pipeline. Sits between the if/mem stage outputs and the memory, and sequences each access through a fixed-latency request/done handshake. Data accesses have priority, with a bounded-starvation guarantee for fetch. While any request is outstanding, the block raises a pipeline stall request.

## Interface
- WAIT_CYCLES, 2: SRAM access latency in cycles, ≥1; the number of cycles the SRAM controls are held per access.
- MAX_STREAK, 4: maximum consecutive MEM grants while fetch is waiting, ≥1.
- clk  in  1  the single clock, rising-edge.
- rst  in  1  reset; synchronous, active-high.
- if_req_i  in  1  fetch request; held high with if_addr_i stable until if_done_o.
- if_addr_i  in  32  fetch word address.
- if_rdata_o  out  32  fetch read data; valid while if_done_o=1, held afterwards.
- if_done_o  out  1  one-cycle fetch completion pulse.
- mem_req_i  in  1  data request (stage chip enable); held with all mem_* fields stable until mem_done_o.
- mem_we_i  in  1  1=write, 0=read.
- mem_sel_i  in  4  byte lane enables; bit 3 is byte address 0 (big-endian lanes).
- mem_addr_i  in  32  data address.
- mem_wdata_i  in  32  write data, already lane-replicated by the MEM stage.
- mem_rdata_o  out  32  read data, raw word; the MEM stage extracts and extends it.
- mem_done_o  out  1  one-cycle data completion pulse, for reads and writes.
- stall_req_o  out  1  pipeline stall request.
- sram_ce_o, sram_we_o  out  1 each  SRAM chip enable and write enable.
- sram_sel_o  out  4  SRAM byte enables.
- sram_addr_o  out  32  SRAM address.
- sram_wdata_o  out  32  SRAM write data.
- sram_rdata_i  in  32  SRAM read data; valid in the last cycle of the hold window.

## Operation
- FSM states:
  - IDLE: sample requests.
  - BUSY: drive the SRAM for WAIT_CYCLES cycles.
  - RESP: pulse done for one cycle.
- IDLE, no request: stay in IDLE.
- IDLE, any request:
  - Choose the grantee.
  - Latch its we/sel/addr/wdata. A fetch latches we=0, sel=1111, wdata=0.
  - Go to BUSY with cnt=0.
- Grant rule:
  - Only mem_req_i high: grant MEM.
  - Only if_req_i high: grant IF.
  - Both high: grant IF if streak==MAX_STREAK, otherwise grant MEM.
- streak counter:
  - On a MEM grant with if_req_i=1: increment, saturating at MAX_STREAK.
  - On an IF grant, or a MEM grant with if_req_i=0: clear to 0.
- BUSY:
  - Outputs: sram_ce_o=1, sram_we_o/sel/addr/wdata come from the latched fields, stable for the whole window.
  - cnt increments each cycle.
  - When cnt==WAIT_CYCLES-1:
    - For a read, register sram_rdata_i into the grantee's rdata output. A write leaves rdata unchanged.
    - Go to RESP.
- RESP:
  - Assert the grantee's done output for exactly one cycle, with SRAM outputs idle.
  - Go to IDLE.
  - Requests are ignored in RESP.
- SRAM outputs outside BUSY: all 0.
- stall_req_o = (if_req_i & ~if_done_o) | (mem_req_i & ~mem_done_o), combinational.
- Requesters drop or renew req on the edge after done. Back-to-back requests from the same port are therefore served with one IDLE cycle in between.

## Timing
- Reset: state=IDLE, cnt=0, streak=0, and every output is 0, including both rdata registers.
- Reset mid-BUSY: the access is abandoned and no done pulse is issued. The SRAM controls drop at that edge, so a partially held write is possible; software must not rely on it.
- Latency: request high in IDLE at cycle 0 → BUSY in cycles 1..WAIT_CYCLES → done in cycle WAIT_CYCLES+1.
- Throughput: one access per WAIT_CYCLES+2 cycles.
- A request arriving during BUSY or RESP waits. It is evaluated in the next IDLE.
- Simultaneous requests are resolved only in IDLE by the grant rule. The losing port keeps stall_req_o asserted.
- Worst-case fetch wait with continuous MEM traffic: MAX_STREAK MEM accesses, then the fetch is granted.
- Address alignment and sel legality are the MEM stage's responsibility and are passed through unchecked.

## Test plan
- Reset → all outputs 0; then rst=1 in cycle 2 of BUSY → sram_ce_o=0 next cycle, no done pulse, state IDLE.
- if_req_i=1, addr=0x100, SRAM returns 0xDEADBEEF (WAIT_CYCLES=2) → sram_ce_o=1 in cycles 1-2, if_done_o=1 with if_rdata_o=0xDEADBEEF in cycle 3, stall_req_o=1 in cycles 0-2.
- mem SB: we=1, sel=0100, addr=0x201, wdata=0x5A5A5A5A → SRAM sees those values for 2 cycles, mem_done_o in cycle 3, mem_rdata_o unchanged.
- if_req_i and mem_req_i raised in the same cycle → MEM served first; IF done at cycle 7 (two full accesses plus the IDLE gap).
- mem_req_i held continuously with if_req_i=1, MAX_STREAK=4 → grants MEM,MEM,MEM,MEM,IF,MEM…; streak clears after the IF grant.
- WAIT_CYCLES=1 parameter run → done in cycle 2; rdata captured from sram_rdata_i in cycle 1.
